// File: rtl/bot_link_pkg.sv
// Shared types and defaults for the multi-bot velocity link.
package bot_link_pkg;

  localparam int unsigned VW_DEF      = 16;
  localparam int unsigned FRAC_DEF    = 11;
  localparam int unsigned TIMEOUT_DEF = 300;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_GRANT,
    ST_WRITE
  } state_e;

  typedef struct packed {
    logic [VW_DEF-1:0] vx;
    logic [VW_DEF-1:0] vy;
  } vel_pair_t;

  // Index width for n entries, never narrower than one bit.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bot_velocity_dispatch_if.sv
// Write-request handshake between the velocity dispatcher and the mailbox writers.
interface bot_velocity_dispatch_if
  import bot_link_pkg::*;
#(
  parameter int unsigned NUM_BOTS = 3,
  parameter int unsigned VW       = VW_DEF
) ();

  localparam int unsigned IW = idx_w(NUM_BOTS);

  logic          wr_valid;
  logic [IW-1:0] wr_bot;
  logic [VW-1:0] wr_vx;
  logic [VW-1:0] wr_vy;
  logic          wr_ack;

  modport master (
    output wr_valid,
    output wr_bot,
    output wr_vx,
    output wr_vy,
    input  wr_ack
  );

  modport slave (
    input  wr_valid,
    input  wr_bot,
    input  wr_vx,
    input  wr_vy,
    output wr_ack
  );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first request after last_i, wrapping modulo NUM_BOTS.
module rr_arbiter
  import bot_link_pkg::*;
#(
  parameter int unsigned NUM_BOTS = 3,
  localparam int unsigned IW      = idx_w(NUM_BOTS)
) (
  input  logic [NUM_BOTS-1:0] req_i,
  input  logic [IW-1:0]       last_i,
  output logic [NUM_BOTS-1:0] gnt_o,
  output logic [IW-1:0]       idx_o,
  output logic                any_o
);

  int unsigned         cand;
  logic [NUM_BOTS-1:0] req_rot;

  always_comb begin
    gnt_o   = '0;
    idx_o   = '0;
    any_o   = 1'b0;
    cand    = 0;
    req_rot = '0;
    for (int unsigned k = 1; k <= NUM_BOTS; k++) begin
      cand    = (32'(last_i) + k) % NUM_BOTS;
      req_rot = req_i >> cand;
      if (!any_o && req_rot[0]) begin
        any_o = 1'b1;
        idx_o = IW'(cand);
        gnt_o = NUM_BOTS'(1) << cand;
      end
    end
  end

endmodule

// File: rtl/bot_velocity_dispatch.sv
// Snapshots per-bot velocity pairs on a write_check edge and delivers them one at a
// time to ready mailboxes, with round-robin arbitration, overrun and timeout flags.
module bot_velocity_dispatch
  import bot_link_pkg::*;
#(
  parameter int unsigned NUM_BOTS = 3,
  parameter int unsigned VW       = VW_DEF,
  parameter int unsigned FRAC     = FRAC_DEF,
  parameter int unsigned TIMEOUT  = TIMEOUT_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   write_check,
  input  logic [NUM_BOTS*VW-1:0] vx_bin,
  input  logic [NUM_BOTS*VW-1:0] vy_bin,
  input  logic [NUM_BOTS-1:0]    bot_ready,
  input  logic                   clr_flags,
  output logic                   en,
  output logic [NUM_BOTS-1:0]    overrun,
  output logic [NUM_BOTS-1:0]    timeout,
  bot_velocity_dispatch_if.master wr
);

  localparam int unsigned   IW        = idx_w(NUM_BOTS);
  localparam int unsigned   AW        = idx_w(TIMEOUT);
  localparam logic [AW-1:0] AGE_LIMIT = AW'(TIMEOUT - 1);

  // FRAC only describes the mailbox-side fixed-point format; reject nonsense values.
  if (FRAC >= VW) begin : g_frac_chk
    $error("FRAC must be smaller than VW");
  end

  state_e              state_q, state_d;
  logic                wc_q;
  logic [NUM_BOTS-1:0] pend_q, pend_d;
  logic [NUM_BOTS-1:0] ovr_q, ovr_d;
  logic [NUM_BOTS-1:0] tmo_q, tmo_d;
  logic [AW-1:0]       age_q [NUM_BOTS];
  logic [AW-1:0]       age_d [NUM_BOTS];
  logic [VW-1:0]       vx_sh_q [NUM_BOTS];
  logic [VW-1:0]       vy_sh_q [NUM_BOTS];
  logic [IW-1:0]       last_q, last_d;
  logic [IW-1:0]       bot_q, bot_d;
  logic [VW-1:0]       vx_q, vx_d;
  logic [VW-1:0]       vy_q, vy_d;
  logic                valid_q, valid_d;

  logic                capture;
  logic [NUM_BOTS-1:0] req;
  logic [NUM_BOTS-1:0] gnt;
  logic [NUM_BOTS-1:0] granted;
  logic [NUM_BOTS-1:0] inflight;
  logic [IW-1:0]       gnt_idx;
  logic                gnt_any;

  assign capture  = write_check & ~wc_q;
  assign req      = pend_q & bot_ready;
  assign granted  = (state_q == ST_GRANT) ? gnt : '0;
  assign inflight = (state_q == ST_WRITE) ? (NUM_BOTS'(1) << bot_q) : '0;

  rr_arbiter #(.NUM_BOTS(NUM_BOTS)) u_rr_arbiter (
    .req_i  (req),
    .last_i (last_q),
    .gnt_o  (gnt),
    .idx_o  (gnt_idx),
    .any_o  (gnt_any)
  );

  // Pending/aging/flag bookkeeping; a capture overrides grant and timeout clears.
  always_comb begin
    pend_d = pend_q & ~granted;
    ovr_d  = clr_flags ? '0 : ovr_q;
    tmo_d  = clr_flags ? '0 : tmo_q;
    for (int i = 0; i < NUM_BOTS; i++) begin
      age_d[i] = age_q[i];
      if (pend_q[i] && !inflight[i]) begin
        age_d[i] = age_q[i] + AW'(1);
      end
      if (pend_q[i] && !granted[i] && (age_q[i] == AGE_LIMIT)) begin
        pend_d[i] = 1'b0;
        tmo_d[i]  = 1'b1;
      end
      if (capture) begin
        age_d[i] = '0;
      end
    end
    if (capture) begin
      ovr_d  = ovr_d | pend_q | inflight;
      pend_d = '1;
    end
  end

  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    bot_d   = bot_q;
    vx_d    = vx_q;
    vy_d    = vy_q;
    last_d  = last_q;
    unique case (state_q)
      ST_IDLE: begin
        if (|req) state_d = ST_GRANT;
      end
      ST_GRANT: begin
        if (gnt_any) begin
          bot_d   = gnt_idx;
          vx_d    = vx_sh_q[gnt_idx];
          vy_d    = vy_sh_q[gnt_idx];
          valid_d = 1'b1;
          state_d = ST_WRITE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WRITE: begin
        if (wr.wr_ack) begin
          valid_d = 1'b0;
          last_d  = bot_q;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      wc_q    <= 1'b0;
      pend_q  <= '0;
      ovr_q   <= '0;
      tmo_q   <= '0;
      last_q  <= IW'(NUM_BOTS - 1);
      bot_q   <= '0;
      vx_q    <= '0;
      vy_q    <= '0;
      valid_q <= 1'b0;
      for (int i = 0; i < NUM_BOTS; i++) begin
        age_q[i]   <= '0;
        vx_sh_q[i] <= '0;
        vy_sh_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      wc_q    <= write_check;
      pend_q  <= pend_d;
      ovr_q   <= ovr_d;
      tmo_q   <= tmo_d;
      last_q  <= last_d;
      bot_q   <= bot_d;
      vx_q    <= vx_d;
      vy_q    <= vy_d;
      valid_q <= valid_d;
      for (int i = 0; i < NUM_BOTS; i++) begin
        age_q[i] <= age_d[i];
        if (capture) begin
          vx_sh_q[i] <= vx_bin[i*VW +: VW];
          vy_sh_q[i] <= vy_bin[i*VW +: VW];
        end
      end
    end
  end

  assign en          = (|pend_q) || (state_q != ST_IDLE);
  assign overrun     = ovr_q;
  assign timeout     = tmo_q;
  assign wr.wr_valid = valid_q;
  assign wr.wr_bot   = bot_q;
  assign wr.wr_vx    = vx_q;
  assign wr.wr_vy    = vy_q;

endmodule

// File: tb/tb_bot_velocity_dispatch.sv
// Directed bench for bot_velocity_dispatch: default-timeout instance for ordering/handshake,
// short-timeout instance for drop behaviour.
module tb_bot_velocity_dispatch;
  import bot_link_pkg::*;

  localparam int unsigned N  = 3;
  localparam int unsigned VW = VW_DEF;

  logic            clk = 1'b0;
  logic            rst, write_check, clr_flags, ack;
  logic [N*VW-1:0] vx_bin, vy_bin;
  logic [N-1:0]    bot_ready;
  logic            en_a, en_b;
  logic [N-1:0]    ovr_a, ovr_b, tmo_a, tmo_b;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int b_writes = 0;
  int b_wr2    = 0;
  logic [55:0] wlog [$];

  vel_pair_t p0, p1, p2, p0_neg;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  bot_velocity_dispatch_if #(.NUM_BOTS(N), .VW(VW)) wr_a ();
  bot_velocity_dispatch_if #(.NUM_BOTS(N), .VW(VW)) wr_b ();
  assign wr_a.wr_ack = ack;
  assign wr_b.wr_ack = ack;

  bot_velocity_dispatch #(.NUM_BOTS(N), .VW(VW), .FRAC(FRAC_DEF), .TIMEOUT(TIMEOUT_DEF)) u_dut_a (
    .clk(clk), .rst(rst), .write_check(write_check), .vx_bin(vx_bin), .vy_bin(vy_bin),
    .bot_ready(bot_ready), .clr_flags(clr_flags), .en(en_a), .overrun(ovr_a),
    .timeout(tmo_a), .wr(wr_a.master)
  );

  bot_velocity_dispatch #(.NUM_BOTS(N), .VW(VW), .FRAC(FRAC_DEF), .TIMEOUT(8)) u_dut_b (
    .clk(clk), .rst(rst), .write_check(write_check), .vx_bin(vx_bin), .vy_bin(vy_bin),
    .bot_ready(bot_ready), .clr_flags(clr_flags), .en(en_b), .overrun(ovr_b),
    .timeout(tmo_b), .wr(wr_b.master)
  );

  // Completed handshakes: {cycle, bot, vx, vy} for instance A, counters for instance B.
  always @(negedge clk) begin
    if (!rst && wr_a.wr_valid && wr_a.wr_ack)
      wlog.push_back({16'(cyc), 8'(wr_a.wr_bot), wr_a.wr_vx, wr_a.wr_vy});
    if (!rst && wr_b.wr_valid && wr_b.wr_ack) begin
      b_writes++;
      if (wr_b.wr_bot == 2'd2) b_wr2++;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst         = 1'b1;
    write_check = 1'b0;
    clr_flags   = 1'b0;
    ack         = 1'b1;
    bot_ready   = '1;
    tick(2);
    rst = 1'b0;
    wlog.delete();
    b_writes = 0;
    b_wr2    = 0;
  endtask

  task automatic load_vel(input vel_pair_t a, input vel_pair_t b, input vel_pair_t c);
    vx_bin = {c.vx, b.vx, a.vx};
    vy_bin = {c.vy, b.vy, a.vy};
  endtask

  task automatic capture_pulse(output int t0);
    write_check = 1'b1;
    t0 = cyc;
    tick();
    write_check = 1'b0;
  endtask

  task automatic wait_writes(input string tag, input int n, input int budget);
    for (int k = 0; k < budget && wlog.size() < n; k++) tick();
    check_eq(tag, wlog.size(), n);
  endtask

  function automatic logic [55:0] wrec(input int i);
    return (i < wlog.size()) ? wlog[i] : '1;
  endfunction

  initial begin
    int t0;
    int n0;
    logic [55:0] r, r1, r2;
    logic [15:0] v0;
    p0     = '{vx: 16'h0800, vy: 16'h0400};
    p1     = '{vx: 16'h007B, vy: 16'h00A4};
    p2     = '{vx: 16'h0014, vy: 16'h0014};
    p0_neg = '{vx: 16'hF800, vy: 16'h0400};
    vx_bin = '0;
    vy_bin = '0;

    do_reset();
    check_eq("rst_outputs", {wr_a.wr_valid, wr_a.wr_bot, wr_a.wr_vx, wr_a.wr_vy}, '0);
    check_eq("rst_flags_a", {en_a, ovr_a, tmo_a}, '0);
    check_eq("rst_flags_b", {en_b, ovr_b, tmo_b}, '0);

    // Capture and round-robin, write_check held high throughout.
    load_vel(p0, p1, p2);
    write_check = 1'b1;
    t0 = cyc;
    tick(2);
    check_eq("t1_valid_c2", wr_a.wr_valid, 1'b0);
    tick();
    check_eq("t1_valid_c3", {wr_a.wr_valid, wr_a.wr_bot}, {1'b1, 2'd0});
    for (int k = 0; k < 40 && en_a; k++) tick();
    check_eq("t1_en_fall_cycle", cyc - t0, 10);
    check_eq("t1_nwrites", wlog.size(), 3);
    r = wrec(0); r1 = wrec(1); r2 = wrec(2);
    check_eq("t1_order", {r[39:32], r1[39:32], r2[39:32]}, {8'd0, 8'd1, 8'd2});
    check_eq("t1_cycles", {int'(r[55:40]) - t0, int'(r1[55:40]) - t0, int'(r2[55:40]) - t0}, {32'd3, 32'd6, 32'd9});
    check_eq("t1_bot0_data", r[31:0], {16'h0800, 16'h0400});
    check_eq("t1_bot1_data", r1[31:0], {16'h007B, 16'h00A4});
    check_eq("t1_bot2_data", r2[31:0], {16'h0014, 16'h0014});
    check_eq("t1_no_overrun", ovr_a, 3'b000);
    write_check = 1'b0;

    // Ready gating: bot1 raised 20 cycles after the capture.
    do_reset();
    load_vel(p0, p1, p2);
    bot_ready = 3'b101;
    capture_pulse(t0);
    tick(19);
    bot_ready = 3'b111;
    wait_writes("t2_nwrites", 3, 20);
    r = wrec(0); r1 = wrec(1); r2 = wrec(2);
    check_eq("t2_order", {r[39:32], r1[39:32], r2[39:32]}, {8'd0, 8'd2, 8'd1});
    check_eq("t2_cycles", {int'(r[55:40]) - t0, int'(r1[55:40]) - t0, int'(r2[55:40]) - t0}, {32'd3, 32'd6, 32'd22});
    check_eq("t2_no_timeout", tmo_a, 3'b000);

    // Timeout on the short-timeout instance, bot2 never ready.
    do_reset();
    load_vel(p0, p1, p2);
    bot_ready = 3'b011;
    capture_pulse(t0);
    tick(7);
    check_eq("t3_pending_c8", {en_b, tmo_b}, {1'b1, 3'b000});
    tick();
    check_eq("t3_timeout_c9", {en_b, tmo_b}, {1'b0, 3'b100});
    bot_ready = 3'b111;
    tick(10);
    check_eq("t3_no_bot2_write", b_wr2, 0);
    check_eq("t3_b_writes", b_writes, 2);
    clr_flags = 1'b1;
    tick();
    clr_flags = 1'b0;
    check_eq("t3_cleared", {ovr_b, tmo_b}, '0);

    // Overrun: second capture while everything is still pending.
    do_reset();
    load_vel(p0, p1, p2);
    bot_ready = 3'b000;
    capture_pulse(t0);
    tick(4);
    load_vel(p0_neg, p1, p2);
    capture_pulse(t0);
    check_eq("t4_overrun", ovr_a, 3'b111);
    bot_ready = 3'b111;
    wait_writes("t4_nwrites", 3, 30);
    n0 = 0;
    v0 = '0;
    for (int i = 0; i < wlog.size(); i++) begin
      r = wlog[i];
      if (r[39:32] == 8'd0) begin
        n0++;
        v0 = r[31:16];
      end
    end
    check_eq("t4_bot0_count", n0, 1);
    check_eq("t4_bot0_vx", v0, 16'hF800);

    // Held-off acknowledge: outputs stable for five cycles.
    do_reset();
    load_vel(p0, p1, p2);
    ack = 1'b0;
    capture_pulse(t0);
    tick(2);
    for (int k = 0; k < 5; k++) begin
      check_eq($sformatf("t5_hold_%0d", k), {wr_a.wr_valid, wr_a.wr_bot, wr_a.wr_vx, wr_a.wr_vy},
               {1'b1, 2'd0, 16'h0800, 16'h0400});
      tick();
    end
    check_eq("t5_no_early_write", wlog.size(), 0);
    ack = 1'b1;
    wait_writes("t5_nwrites", 3, 30);
    r = wrec(0); r1 = wrec(1); r2 = wrec(2);
    check_eq("t5_order", {r[39:32], r1[39:32], r2[39:32]}, {8'd0, 8'd1, 8'd2});
    check_eq("t5_cycles", {int'(r[55:40]) - t0, int'(r1[55:40]) - t0}, {32'd8, 32'd11});

    // Reset in the middle of a write.
    do_reset();
    load_vel(p0, p1, p2);
    ack = 1'b0;
    capture_pulse(t0);
    tick(2);
    check_eq("t6_in_write", wr_a.wr_valid, 1'b1);
    rst = 1'b1;
    tick();
    check_eq("t6_rst_outputs", {wr_a.wr_valid, wr_a.wr_bot, wr_a.wr_vx, wr_a.wr_vy}, '0);
    check_eq("t6_rst_flags", {en_a, ovr_a, tmo_a}, '0);
    rst = 1'b0;
    ack = 1'b1;
    tick(20);
    check_eq("t6_no_writes", wlog.size(), 0);
    check_eq("t6_idle_en", en_a, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
